// File: rtl/raster_mem_sink_if.sv
// Scanner sample handshake and the single-beat Wishbone-style write bus, seen from
// the memory sink (master) or from its surroundings (slave: scanner plus memory).
interface raster_mem_sink_if #(
    parameter int unsigned DATA_WID = 24,
    parameter int unsigned BUS_WID  = 32
);
    // Scanner handshake
    logic [DATA_WID-1:0] data;
    logic                mem_commit;
    logic                mem_finished;

    // Write bus
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [BUS_WID-1:0]  wb_adr;
    logic [BUS_WID-1:0]  wb_dat_w;
    logic [3:0]          wb_sel;
    logic                wb_ack;

    // The sink answers the scanner and masters the bus.
    modport master (
        input  data,
        input  mem_commit,
        output mem_finished,
        output wb_cyc,
        output wb_stb,
        output wb_we,
        output wb_adr,
        output wb_dat_w,
        output wb_sel,
        input  wb_ack
    );

    // Scanner and memory side.
    modport slave (
        output data,
        output mem_commit,
        input  mem_finished,
        input  wb_cyc,
        input  wb_stb,
        input  wb_we,
        input  wb_adr,
        input  wb_dat_w,
        input  wb_sel,
        output wb_ack
    );
endinterface

// File: rtl/raster_mem_sink.sv
// Memory-side responder for the raster scanner: each committed ADC word is
// sign-extended and written into a circular word buffer in RAM. A full buffer
// withholds mem_finished, which back-pressures the scan.
module raster_mem_sink #(
    parameter int unsigned DATA_WID = 24,
    parameter int unsigned BUS_WID  = 32,
    parameter int unsigned PTR_WID  = 16
) (
    input  logic               clk,
    input  logic               rst_L,
    raster_mem_sink_if.master  bus,
    input  logic [BUS_WID-1:0] base_addr,
    input  logic [PTR_WID-1:0] buf_words,
    input  logic [PTR_WID-1:0] rd_ptr,
    input  logic               clear,
    output logic [PTR_WID-1:0] wr_ptr,
    output logic               stalled,
    output logic               cfg_err
);

    localparam logic [PTR_WID-1:0] PtrOne = PTR_WID'(1);
    localparam logic [PTR_WID-1:0] PtrTwo = PTR_WID'(2);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWrite,
        StHold
    } state_e;

    state_e state_q, state_d;

    // Configuration latched by clear
    logic [BUS_WID-1:0]  base_q;
    logic [PTR_WID-1:0]  size_q;
    logic                cfg_err_q;

    // Buffer and sample state
    logic [PTR_WID-1:0]  wr_ptr_q;
    logic [DATA_WID-1:0] data_q;
    logic                stalled_q;

    // Derived control
    logic [PTR_WID-1:0]  next_ptr;
    logic                full;
    logic                take_clear;
    logic                take_commit;
    logic                bus_done;
    logic                in_write;
    logic [BUS_WID-1:0]  word_off;
    logic [BUS_WID-1:0]  sample_ext;

    // Buffer pointer arithmetic and event decode; rd_ptr is used live so a
    // consumer advance is seen in the same cycle CHECK evaluates fullness.
    always_comb begin
        next_ptr    = (wr_ptr_q == size_q - PtrOne) ? '0 : wr_ptr_q + PtrOne;
        full        = (next_ptr == rd_ptr);
        take_clear  = (state_q == StIdle) && clear;
        // clear takes priority; a coincident commit is taken on the next cycle
        take_commit = (state_q == StIdle) && !clear && bus.mem_commit && !cfg_err_q;
        bus_done    = (state_q == StWrite) && bus.wb_ack;
        in_write    = (state_q == StWrite);
        word_off    = BUS_WID'({wr_ptr_q, 2'b00});
        sample_ext  = {{(BUS_WID - DATA_WID){data_q[DATA_WID-1]}}, data_q};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_commit) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!bus.mem_commit) begin
                    state_d = StIdle;
                end else if (!full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // An aborted commit still completes its bus cycle, then skips HOLD.
                if (bus.wb_ack) begin
                    state_d = bus.mem_commit ? StHold : StIdle;
                end
            end
            StHold: begin
                if (!bus.mem_commit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: bus strobes and data only while a write is in flight
    always_comb begin
        bus.mem_finished = (state_q == StHold);
        bus.wb_cyc       = in_write;
        bus.wb_stb       = in_write;
        bus.wb_we        = in_write;
        bus.wb_sel       = in_write ? 4'b1111 : 4'b0000;
        bus.wb_adr       = in_write ? base_q + word_off : '0;
        bus.wb_dat_w     = in_write ? sample_ext : '0;
    end

    // Configuration, write pointer, sample latch and stall flag
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            base_q    <= '0;
            size_q    <= '0;
            cfg_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            data_q    <= '0;
            stalled_q <= 1'b0;
        end else begin
            if (take_clear) begin
                base_q    <= base_addr;
                size_q    <= buf_words;
                cfg_err_q <= (buf_words < PtrTwo);
                wr_ptr_q  <= '0;
                stalled_q <= 1'b0;
            end
            if (take_commit) begin
                data_q <= bus.data;
            end
            if (state_q == StCheck) begin
                stalled_q <= bus.mem_commit && full;
            end
            if (bus_done) begin
                wr_ptr_q <= next_ptr;
            end
        end
    end

    assign wr_ptr  = wr_ptr_q;
    assign stalled = stalled_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_raster_mem_sink.sv
// Bench for raster_mem_sink: a bus responder with programmable ack delay checks every
// write against a queue of expected {address, data} pairs pushed by the stimulus.
module tb_raster_mem_sink;

    localparam int unsigned DATA_WID = 24;
    localparam int unsigned BUS_WID  = 32;
    localparam int unsigned PTR_WID  = 16;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic [23:0] data;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [15:0] wrp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [31:0] base_addr;
    logic [15:0] buf_words;
    logic [15:0] rd_ptr;
    logic        clear;
    logic [15:0] wr_ptr;
    logic        stalled;
    logic        cfg_err;

    raster_mem_sink_if #(.DATA_WID(DATA_WID), .BUS_WID(BUS_WID)) bus ();

    raster_mem_sink #(
        .DATA_WID(DATA_WID),
        .BUS_WID (BUS_WID),
        .PTR_WID (PTR_WID)
    ) dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .bus      (bus),
        .base_addr(base_addr),
        .buf_words(buf_words),
        .rd_ptr   (rd_ptr),
        .clear    (clear),
        .wr_ptr   (wr_ptr),
        .stalled  (stalled),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string step   = "init";

    exp_t  exp_q[$];
    int    ack_delay = 0;
    int    wait_cnt  = 0;
    int    stb_cnt   = 0;
    int    wr_cnt    = 0;
    bit    fin_seen  = 1'b0;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    exp_t  rsp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h, expected %h", step, name, act, exp);
        end
    endtask

    // Memory model: acks after ack_delay wait cycles and scores each write.
    always @(negedge clk) begin
        if (bus.mem_finished) fin_seen = 1'b1;
        if (!rst_L) begin
            bus.wb_ack = 1'b0;
            wait_cnt   = 0;
        end else if (bus.wb_ack) begin
            bus.wb_ack = 1'b0;
            wait_cnt   = 0;
        end else if (bus.wb_cyc && bus.wb_stb) begin
            stb_cnt++;
            if (wait_cnt == 0) begin
                cap_adr = bus.wb_adr;
                cap_dat = bus.wb_dat_w;
            end else begin
                chk("adr_stable", bus.wb_adr, cap_adr);
                chk("dat_stable", bus.wb_dat_w, cap_dat);
            end
            if (wait_cnt >= ack_delay) begin
                bus.wb_ack = 1'b1;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/unexpected_write: got adr %h dat %h, expected no write",
                             step, bus.wb_adr, bus.wb_dat_w);
                end else begin
                    rsp_e = exp_q.pop_front();
                    chk("wb_adr", bus.wb_adr, rsp_e.adr);
                    chk("wb_dat_w", bus.wb_dat_w, rsp_e.dat);
                    chk("wb_sel", {28'd0, bus.wb_sel}, 32'hF);
                    chk("wb_we", {31'd0, bus.wb_we}, 32'd1);
                end
            end
            wait_cnt++;
        end
    end

    task automatic do_clear(input logic [31:0] b, input logic [15:0] n);
        base_addr = b;
        buf_words = n;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_fin(input int budget, output int lat);
        lat = 0;
        while (!bus.mem_finished && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_commit();
        int n = 0;
        bus.mem_commit = 1'b0;
        while (bus.mem_finished && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fin_drop_lat", n, 1);
    endtask

    task automatic sb_commit(input logic [23:0] d, input logic [31:0] adr,
                             input logic [31:0] dat, input int exp_lat,
                             input logic [15:0] exp_wrp);
        exp_t e;
        int   lat;
        e.adr = adr;
        e.dat = dat;
        exp_q.push_back(e);
        bus.data       = d;
        bus.mem_commit = 1'b1;
        wait_fin(40, lat);
        chk("latency", lat, exp_lat);
        chk("finished", {31'd0, bus.mem_finished}, 32'd1);
        release_commit();
        chk("wr_ptr", {16'd0, wr_ptr}, {16'd0, exp_wrp});
    endtask

    vec_t vecs[5];

    initial begin
        int   lat;
        int   s0;
        int   w0;
        int   n;
        exp_t e;

        rst_L          = 1'b0;
        clear          = 1'b0;
        base_addr      = '0;
        buf_words      = '0;
        rd_ptr         = '0;
        bus.data       = '0;
        bus.mem_commit = 1'b0;
        bus.wb_ack     = 1'b0;
        repeat (3) @(negedge clk);

        step = "reset";
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd0);
        chk("stalled", {31'd0, stalled}, 32'd0);
        chk("cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("mem_finished", {31'd0, bus.mem_finished}, 32'd0);
        chk("wb_cyc", {31'd0, bus.wb_cyc}, 32'd0);
        chk("wb_adr", bus.wb_adr, 32'd0);
        rst_L = 1'b1;
        @(negedge clk);

        // Basic writes, single-cycle ack, base 0x1000_0000, 8 words
        vecs[0] = '{24'h800001, 32'h1000_0000, 32'hFF80_0001, 16'd1, 3};
        vecs[1] = '{24'h7FFFFF, 32'h1000_0004, 32'h007F_FFFF, 16'd2, 3};
        vecs[2] = '{24'h000000, 32'h1000_0008, 32'h0000_0000, 16'd3, 3};
        vecs[3] = '{24'hFFFFFF, 32'h1000_000C, 32'hFFFF_FFFF, 16'd4, 3};
        vecs[4] = '{24'h123456, 32'h1000_0010, 32'h0012_3456, 16'd5, 3};
        do_clear(32'h1000_0000, 16'd8);
        step = "clear8";
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd0);
        chk("cfg_err", {31'd0, cfg_err}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step = $sformatf("vec%0d", i);
            sb_commit(vecs[i].data, vecs[i].adr, vecs[i].dat, vecs[i].lat, vecs[i].wrp);
        end

        // Wrap, size 4, base near the top of the address space
        step = "wrap";
        rd_ptr = 16'd0;
        do_clear(32'hFFFF_FFF8, 16'd4);
        sb_commit(24'h000011, 32'hFFFF_FFF8, 32'h0000_0011, 3, 16'd1);
        sb_commit(24'h000022, 32'hFFFF_FFFC, 32'h0000_0022, 3, 16'd2);
        rd_ptr = 16'd2;
        sb_commit(24'h800033, 32'h0000_0000, 32'hFF80_0033, 3, 16'd3);
        sb_commit(24'h000044, 32'h0000_0004, 32'h0000_0044, 3, 16'd0);
        sb_commit(24'h000055, 32'hFFFF_FFF8, 32'h0000_0055, 3, 16'd1);

        // Fourth commit finds the buffer full
        step = "full";
        s0 = stb_cnt;
        bus.data       = 24'h00ABCD;
        bus.mem_commit = 1'b1;
        repeat (4) @(negedge clk);
        chk("stalled", {31'd0, stalled}, 32'd1);
        chk("mem_finished", {31'd0, bus.mem_finished}, 32'd0);
        chk("no_bus", stb_cnt, s0);
        e.adr = 32'hFFFF_FFFC;
        e.dat = 32'h0000_ABCD;
        exp_q.push_back(e);
        rd_ptr = 16'd3;
        wait_fin(20, lat);
        chk("resume_lat", lat, 2);
        chk("stalled_clr", {31'd0, stalled}, 32'd0);
        release_commit();
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd2);

        // Abort while stalled (wr_ptr 2, rd_ptr 3)
        step = "abort_check";
        s0 = stb_cnt;
        fin_seen = 1'b0;
        bus.data       = 24'h555555;
        bus.mem_commit = 1'b1;
        repeat (3) @(negedge clk);
        chk("stalled", {31'd0, stalled}, 32'd1);
        bus.mem_commit = 1'b0;
        repeat (2) @(negedge clk);
        chk("stalled_clr", {31'd0, stalled}, 32'd0);
        repeat (3) @(negedge clk);
        chk("fin_seen", {31'd0, fin_seen}, 32'd0);
        chk("no_bus", stb_cnt, s0);
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd2);
        rd_ptr = 16'd0;
        sb_commit(24'hAAAAAA, 32'h0000_0000, 32'hFFAA_AAAA, 3, 16'd3);

        // Slow bus: ack after 5 wait cycles
        step = "slow";
        rd_ptr    = 16'd2;
        ack_delay = 5;
        s0        = stb_cnt;
        sb_commit(24'h765432, 32'h0000_0004, 32'h0076_5432, 8, 16'd0);
        chk("stb_cycles", stb_cnt - s0, 6);
        ack_delay = 0;

        // Commit dropped while the write is in flight
        step = "abort_write";
        ack_delay = 4;
        fin_seen  = 1'b0;
        w0        = wr_cnt;
        e.adr = 32'hFFFF_FFF8;
        e.dat = 32'hFFF0_0000;
        exp_q.push_back(e);
        bus.data       = 24'hF00000;
        bus.mem_commit = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_write", {31'd0, bus.wb_stb}, 32'd1);
        bus.mem_commit = 1'b0;
        n = 0;
        while (wr_cnt == w0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("writes", wr_cnt - w0, 1);
        chk("fin_seen", {31'd0, fin_seen}, 32'd0);
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd1);
        ack_delay = 0;

        // Config error, then clear coincident with a held commit
        step = "cfg_err";
        rd_ptr = 16'd0;
        do_clear(32'h3000_0000, 16'd1);
        chk("cfg_err", {31'd0, cfg_err}, 32'd1);
        s0 = stb_cnt;
        fin_seen = 1'b0;
        bus.data       = 24'h0F0F0F;
        bus.mem_commit = 1'b1;
        repeat (10) @(negedge clk);
        chk("fin_seen", {31'd0, fin_seen}, 32'd0);
        chk("no_bus", stb_cnt, s0);
        step = "clear_commit";
        e.adr = 32'h3000_0000;
        e.dat = 32'h000F_0F0F;
        exp_q.push_back(e);
        buf_words = 16'd2;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_fin(40, lat);
        chk("latency", lat + 1, 4);
        chk("cfg_err", {31'd0, cfg_err}, 32'd0);
        release_commit();
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd1);
        step = "size2_full";
        bus.mem_commit = 1'b1;
        repeat (4) @(negedge clk);
        chk("stalled", {31'd0, stalled}, 32'd1);
        chk("mem_finished", {31'd0, bus.mem_finished}, 32'd0);
        bus.mem_commit = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        // Reset in the middle of a slow write
        step = "reset_mid";
        do_clear(32'h4000_0000, 16'd8);
        ack_delay = 20;
        e.adr = 32'h4000_0000;
        e.dat = 32'h0000_0001;
        exp_q.push_back(e);
        bus.data       = 24'h000001;
        bus.mem_commit = 1'b1;
        n = 0;
        while (!bus.wb_stb && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wb_stb", {31'd0, bus.wb_stb}, 32'd1);
        rst_L = 1'b0;
        @(negedge clk);
        chk("wb_cyc", {31'd0, bus.wb_cyc}, 32'd0);
        chk("wb_stb", {31'd0, bus.wb_stb}, 32'd0);
        chk("wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("wb_sel", {28'd0, bus.wb_sel}, 32'd0);
        chk("wb_adr", bus.wb_adr, 32'd0);
        chk("wb_dat_w", bus.wb_dat_w, 32'd0);
        chk("mem_finished", {31'd0, bus.mem_finished}, 32'd0);
        chk("wr_ptr", {16'd0, wr_ptr}, 32'd0);
        chk("stalled", {31'd0, stalled}, 32'd0);
        exp_q.delete();
        bus.mem_commit = 1'b0;
        ack_delay      = 0;
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);

        step = "post_reset";
        do_clear(32'h5000_0000, 16'd8);
        sb_commit(24'h800000, 32'h5000_0000, 32'hFF80_0000, 3, 16'd1);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
